// File: rtl/pwm_ramp_controller.sv
// Ramp sequencer for a pwm duty_cycle input. Accepts target/step commands over valid/ready
// and moves the duty toward the target, changing it only at PWM period boundaries.
module pwm_ramp_controller #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_target,
  input  logic [7:0] cmd_step,
  input  logic       stop,
  output logic [7:0] duty_cycle,
  output logic       period_end,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DivW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(PRESCALE - 1);

  typedef enum logic [0:0] {StIdle, StRamp} state_e;

  state_e          state_q;
  logic [7:0]      phase_q;
  logic [7:0]      duty_q;
  logic [7:0]      target_q;
  logic [7:0]      step_q;
  logic [DivW-1:0] div_q;
  logic            done_q;

  logic            boundary;
  logic [8:0]      up_sum;
  logic [8:0]      dn_diff;
  logic [7:0]      next_duty;

  assign boundary = (phase_q == 8'hFF);

  // Free-running phase counter mirroring the pwm counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= 8'h00;
    end else begin
      phase_q <= phase_q + 8'h01;
    end
  end

  // Next duty value, clamped to the target; 9-bit math catches wrap in both directions.
  always_comb begin
    up_sum    = {1'b0, duty_q} + {1'b0, step_q};
    dn_diff   = {1'b0, duty_q} - {1'b0, step_q};
    next_duty = target_q;
    if (step_q == 8'h00) begin
      next_duty = target_q;
    end else if (duty_q < target_q) begin
      next_duty = (up_sum > {1'b0, target_q}) ? target_q : up_sum[7:0];
    end else begin
      // dn_diff[8] set means the subtraction went below zero.
      next_duty = (dn_diff[8] || (dn_diff[7:0] < target_q)) ? target_q : dn_diff[7:0];
    end
  end

  // Command FSM: latch on handshake, step duty at every PRESCALE-th boundary, abort on stop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      duty_q   <= 8'h00;
      target_q <= 8'h00;
      step_q   <= 8'h00;
      div_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && !stop) begin
            target_q <= cmd_target;
            step_q   <= cmd_step;
            div_q    <= '0;
            state_q  <= StRamp;
          end
        end
        StRamp: begin
          if (stop) begin
            // Stop wins over a coinciding step boundary: duty is frozen as-is.
            div_q   <= '0;
            state_q <= StIdle;
          end else if (boundary) begin
            if (div_q == DivLast) begin
              div_q  <= '0;
              duty_q <= next_duty;
              if (next_duty == target_q) begin
                done_q  <= 1'b1;
                state_q <= StIdle;
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = (state_q == StIdle) && !stop;
  assign busy       = (state_q == StRamp);
  assign done       = done_q;
  assign duty_cycle = duty_q;
  assign period_end = boundary;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: two instances (PRESCALE 1 and 3) share one stimulus stream and
// are checked every cycle against a behavioural model, plus literal checks of key scenarios.
module tb_pwm_ramp_controller;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic [7:0] cmd_target;
  logic [7:0] cmd_step;
  logic       stop;

  logic       ready [2];
  logic [7:0] duty  [2];
  logic       pend  [2];
  logic       busy  [2];
  logic       done  [2];

  int  cmp_n  = 0;
  int  fail_n = 0;
  bit  chk_en = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string nm, input int act, input int exp);
    cmp_n++;
    if (act != exp) begin
      fail_n++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string nm);
    cmp_n++;
    fail_n++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned P = (g == 0) ? 1 : 3;

    pwm_ramp_controller #(.PRESCALE(P)) u_dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (ready[g]),
      .cmd_target (cmd_target),
      .cmd_step   (cmd_step),
      .stop       (stop),
      .duty_cycle (duty[g]),
      .period_end (pend[g]),
      .busy       (busy[g]),
      .done       (done[g])
    );

    // Model: cycles since reset give the phase; a ramp counts completed periods and moves the
    // duty by at most one step toward the target every P of them.
    int m_cycles;
    int m_duty;
    int m_tgt;
    int m_step;
    int m_periods;
    bit m_busy;
    bit m_done;
    int m_phase;
    assign m_phase = m_cycles % 256;

    always @(posedge clock or negedge reset) begin
      int nd;
      int np;
      int diff;
      bit nb;
      bit ndn;
      if (!reset) begin
        m_cycles  <= 0;
        m_duty    <= 0;
        m_tgt     <= 0;
        m_step    <= 0;
        m_periods <= 0;
        m_busy    <= 0;
        m_done    <= 0;
      end else begin
        nd  = m_duty;
        np  = m_periods;
        nb  = m_busy;
        ndn = 0;
        if (m_busy) begin
          if (stop) begin
            nb = 0;
          end else if (m_phase == 255) begin
            np = m_periods + 1;
            if (np % P == 0) begin
              diff = m_tgt - m_duty;
              if (m_step == 0 || (diff <= m_step && -diff <= m_step)) nd = m_tgt;
              else if (diff > 0) nd = m_duty + m_step;
              else nd = m_duty - m_step;
              if (nd == m_tgt) begin
                nb  = 0;
                ndn = 1;
              end
            end
          end
        end else if (cmd_valid && !stop) begin
          nb = 1;
          np = 0;
          m_tgt  <= cmd_target;
          m_step <= cmd_step;
        end
        m_duty    <= nd;
        m_periods <= np;
        m_busy    <= nb;
        m_done    <= ndn;
        m_cycles  <= m_cycles + 1;
      end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
      if (chk_en) begin
        check($sformatf("duty[%0d]", g), int'(duty[g]), m_duty);
        check($sformatf("ready[%0d]", g), int'(ready[g]), int'(!m_busy && !stop));
        check($sformatf("busy[%0d]", g), int'(busy[g]), int'(m_busy));
        check($sformatf("done[%0d]", g), int'(done[g]), int'(m_done));
        check($sformatf("period_end[%0d]", g), int'(pend[g]), int'(m_phase == 255));
      end
    end
  end

  task automatic wait_p0();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (g_dut[0].m_phase != 0 && n < 600);
    if (n >= 600) timeout("wait_phase0");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((g_dut[0].m_busy || g_dut[1].m_busy) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) timeout("wait_idle");
  endtask

  // Present a one-cycle command a little after a period starts, with instance 0 idle.
  task automatic send(input logic [7:0] tgt, input logic [7:0] stp);
    int n = 0;
    while ((g_dut[0].m_busy || g_dut[0].m_phase != 10) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) timeout("send");
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_step   = stp;
    @(negedge clock);
    cmd_valid  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s duty[%0d]", tag, i), int'(duty[i]), 0);
      check($sformatf("%s ready[%0d]", tag, i), int'(ready[i]), 1);
      check($sformatf("%s busy[%0d]", tag, i), int'(busy[i]), 0);
      check($sformatf("%s done[%0d]", tag, i), int'(done[i]), 0);
      check($sformatf("%s period_end[%0d]", tag, i), int'(pend[i]), 0);
    end
  endtask

  initial begin
    int exp1 [6] = '{0, 0, 1, 1, 1, 2};
    int n;
    cmd_valid  = 1'b0;
    cmd_target = 8'h00;
    cmd_step   = 8'h00;
    stop       = 1'b0;
    reset      = 1'b1;
    #1 reset = 1'b0;
    #2 check_reset_values("reset");
    chk_en = 1'b1;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;

    // Basic ramp 0 -> 0x40 in steps of 0x10.
    send(8'h40, 8'h10);
    for (int k = 1; k <= 4; k++) begin
      wait_p0();
      check("ramp40 duty", int'(duty[0]), 16 * k);
      check("ramp40 done", int'(done[0]), int'(k == 4));
    end
    @(negedge clock);
    check("ramp40 busy after", int'(busy[0]), 0);
    check("ramp40 done after", int'(done[0]), 0);

    // Clamping at the top and bottom of the range.
    send(8'hF8, 8'h00);
    wait_p0();
    check("jump F8", int'(duty[0]), 8'hF8);
    send(8'hFF, 8'h10);
    wait_p0();
    check("clamp FF", int'(duty[0]), 8'hFF);
    check("clamp FF done", int'(done[0]), 1);
    send(8'h05, 8'h00);
    wait_p0();
    send(8'h00, 8'h10);
    wait_p0();
    check("clamp 00", int'(duty[0]), 0);
    check("clamp 00 done", int'(done[0]), 1);

    // Stop mid-ramp at 0x30.
    send(8'h80, 8'h10);
    repeat (3) wait_p0();
    check("pre-stop duty", int'(duty[0]), 8'h30);
    repeat (20) @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop busy", int'(busy[0]), 0);
    check("stop duty", int'(duty[0]), 8'h30);
    wait_p0();
    check("stop hold duty", int'(duty[0]), 8'h30);
    check("stop no done", int'(done[0]), 0);

    // Stop on the same edge as a step boundary.
    send(8'h80, 8'h10);
    n = 0;
    while (g_dut[0].m_phase != 255 && n < 600) begin
      @(negedge clock);
      n++;
    end
    if (n >= 600) timeout("wait_phase255");
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("stop@boundary duty", int'(duty[0]), 8'h30);
    check("stop@boundary busy", int'(busy[0]), 0);
    check("stop@boundary done", int'(done[0]), 0);

    // Stop blocks acceptance in idle.
    stop      = 1'b1;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clock);
      check("idle stop ready", int'(ready[0]), 0);
    end
    stop      = 1'b0;
    cmd_valid = 1'b0;
    check("idle stop busy", int'(busy[0]), 0);

    // PRESCALE=3 instance: steps three periods apart.
    wait_idle();
    send(8'h00, 8'h00);
    wait_idle();
    send(8'h02, 8'h01);
    for (int k = 0; k < 6; k++) begin
      wait_p0();
      check($sformatf("prescale3 duty p%0d", k), int'(duty[1]), exp1[k]);
      check($sformatf("prescale3 done p%0d", k), int'(done[1]), int'(k == 5));
    end

    // Asynchronous reset between edges mid-ramp.
    wait_idle();
    send(8'hC0, 8'h08);
    repeat (2) wait_p0();
    #2 reset = 1'b0;
    #1 check_reset_values("async reset");
    @(negedge clock);
    #2 reset = 1'b1;
    send(8'h20, 8'h10);
    wait_p0();
    check("post-reset duty 1", int'(duty[0]), 8'h10);
    wait_p0();
    check("post-reset duty 2", int'(duty[0]), 8'h20);
    check("post-reset done", int'(done[0]), 1);

    // Random traffic checked by the per-cycle model comparison.
    repeat (30000) begin
      @(negedge clock);
      cmd_valid  = ($urandom_range(0, 15) == 0);
      cmd_target = 8'($urandom);
      cmd_step   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(8, 255));
      stop       = ($urandom_range(0, 999) == 0);
    end
    @(negedge clock);
    cmd_valid = 1'b0;
    stop      = 1'b0;
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencer that drives the 8-bit `duty_cycle` input of a `pwm` instance. It accepts ramp commands over a valid/ready handshake and steps the duty cycle toward a target. Updates happen only at PWM period boundaries, so a period is never cut short or stretched mid-cycle. It sits between the register/command layer and the `pwm` output stage, for example for LED fades or motor soft-start.

## Interface
Parameters:
- `PRESCALE`, default 1. Number of complete PWM periods between ramp steps. Legal range is 1..256.

Ports:
- `clock`  in  1  system clock, shared with the `pwm` instance.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both high at a rising edge.
- `cmd_target`  in  8  final duty cycle, 0..255.
- `cmd_step`  in  8  duty increment per ramp step. 0 means jump to the target at the next boundary.
- `stop`  in  1  abort the ramp and freeze the current duty.
- `duty_cycle`  out  8  connects to `pwm.duty_cycle`.
- `period_end`  out  1  high during the last clock of each PWM period (`phase == 255`).
- `busy`  out  1  high in the RAMP state.
- `done`  out  1  one-cycle pulse when the target is reached.

## Operation
- Internal 8-bit `phase` counter increments every clock and wraps 255→0. It mirrors the `pwm` counter.
- A boundary is a rising edge at which `phase == 255`.
- Internal `div` counter, width sized for PRESCALE:
  - Increments at each boundary in RAMP.
  - At `div == PRESCALE-1`, the boundary is a step boundary and `div` clears.
  - `div` clears on entry to RAMP.
- States:
  - IDLE: `cmd_ready = ~stop`, `busy = 0`. On handshake, latch `cmd_target` and `cmd_step`, then go to RAMP.
  - RAMP: `cmd_ready = 0`, `busy = 1`.
    - At each step boundary, update duty: d' = (step==0) ? target : (d<target ? min(d+step, target) : max(d-step, target)).
    - Compute with a 9-bit intermediate. No wrap and no overshoot is permitted.
    - When d' == target, drive `done` high for the following cycle and go to IDLE.
    - If d == target on entry, the first step boundary still occurs, then `done` pulses and the block returns to IDLE.
  - `stop` high in RAMP: the next edge returns to IDLE. `duty_cycle` holds its value, `done` is not asserted, and `div` clears.
- If `stop` and a step boundary coincide, `stop` wins and duty is not updated.
- In IDLE, `stop` blocks acceptance (`cmd_ready = 0`). No command is latched.
- `duty_cycle` is a register. It never changes except at a step boundary, so `pwm` sees a stable value for whole periods.

## Timing
- Reset values:
  - `duty_cycle` = 0, `phase` = 0, `div` = 0, state = IDLE.
  - `cmd_ready` = 1 (gated by `stop`), `busy` = 0, `done` = 0.
  - `period_end` = 0.
- Reset is asynchronous. Any state, including mid-ramp, returns to these values immediately.
- Phase alignment with `pwm` is guaranteed when both start from counter 0 on the same edge. The integrator releases `reset` at power-up. A mid-operation reset may misalign the two by at most one period; this is accepted.
- Handshake to first update: from 1 to 256×PRESCALE clocks, depending on `phase` at acceptance.
- A new duty is visible on `duty_cycle` in the cycle with `phase == 0` that follows the step boundary.
- `done` is high in that same `phase == 0` cycle. `cmd_ready` rises in that cycle as well.
- A new command can be accepted in the cycle right after `done`.
- Ramp length: ceil(|target − d| / step) step boundaries. This is 1 when step = 0 or the start duty already equals the target.
- `cmd_target`/`cmd_step` are sampled only at the handshake. Changes afterward are ignored.

## Test plan
- Reset, then command target=0x40, step=0x10, PRESCALE=1 → `duty_cycle` goes 0x10, 0x20, 0x30, 0x40 at 4 consecutive `phase == 0` cycles. `done` pulses once with the last value; `busy` is low afterward.
- Duty 0xF8, target=0xFF, step=0x10 → a single update to 0xFF with no wrap to 0x08. Then duty=0x05, target=0x00, step=0x10 → 0x00 with no underflow.
- PRESCALE=3, duty 0, target=0x02, step=1 → updates occur 768 clocks apart. `duty_cycle` is constant within every period.
- `stop` asserted mid-ramp at duty 0x30 (target 0x80) → duty holds at 0x30, no `done`, IDLE on the next edge. `stop` on the same edge as a step boundary → no update.
- `cmd_valid` held with `stop` high in IDLE → no acceptance. `cmd_valid` during RAMP → `cmd_ready` = 0 and no accept until after `done`.
- Async `reset` pulse mid-ramp, between clock edges → all outputs at their reset values before the next edge. A fresh command ramps correctly from 0.
